// File: rtl/contador_pkg.sv
// Shared mode encodings for the contador counter family.
// Imported by both the counter top and its next-value logic.
package contador_pkg;

    typedef enum logic [1:0] {
        MODO_UP        = 2'b00,
        MODO_DOWN      = 2'b01,
        MODO_DOWN_STEP = 2'b10,
        MODO_LOAD      = 2'b11
    } modo_t;

endpackage

// File: rtl/contador_next.sv
// Next-value and carry/borrow logic for contador_param: purely combinational.
// Saturating arithmetic replaces wrap-around when CONTADOR_SAT_EN is defined.
module contador_next
    import contador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] Q_MAX  = '1;

    logic borrow_step;
    assign borrow_step = (q < STEP_V);

    // wrap doubles as the rco source: carry/borrow when wrapping, "pinned at the bound" when saturating
    always_comb begin
        nxt  = q;
        wrap = 1'b0;
        case (modo_t'(modo))
            MODO_UP: begin
                wrap = (q == Q_MAX);
`ifdef CONTADOR_SAT_EN
                nxt  = wrap ? q : q + 1'b1;
`else
                nxt  = q + 1'b1;
`endif
            end
            MODO_DOWN: begin
                wrap = (q == '0);
`ifdef CONTADOR_SAT_EN
                nxt  = wrap ? q : q - 1'b1;
`else
                nxt  = q - 1'b1;
`endif
            end
            MODO_DOWN_STEP: begin
`ifdef CONTADOR_SAT_EN
                wrap = (q == '0);
                nxt  = borrow_step ? '0 : q - STEP_V;
`else
                wrap = borrow_step;
                nxt  = q - STEP_V;
`endif
            end
            MODO_LOAD: begin
                nxt  = d;
                wrap = 1'b0;
            end
            default: begin
                nxt  = q;
                wrap = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/contador_param.sv
// Cascadable up/down/step/load counter with registered ripple-carry-out; optional CONTADOR_SAT_EN saturates.
// Latency: one cycle from inputs to Q/rco, no pipeline.
// Backpressure: none; enable/ci low simply hold Q and clear rco.
module contador_param
    import contador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ci,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco
);

    logic [WIDTH-1:0] nxt;
    logic             wrap;
    logic             advance;

    contador_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .q    (Q),
        .modo (modo),
        .d    (D),
        .nxt  (nxt),
        .wrap (wrap)
    );

    // Load ignores ci so a chained stage can still be preset independently
    assign advance = enable && (ci || (modo == MODO_LOAD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q   <= '0;
            rco <= 1'b0;
        end else begin
            rco <= advance && wrap;
            if (advance) begin
                Q <= nxt;
            end
        end
    end

endmodule
